// File: rtl/id_stage.sv
// Decode / operand-fetch stage: splits the instruction, reads and forwards
// operands, resolves hazards into the ID/EX register. Optional ID_FWD_EN.
module id_stage #(
  parameter logic [3:0] LW_OP  = 4'b1000,
  parameter logic [3:0] HLT_OP = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  output logic        if_stall,
  input  logic        flush,
  input  logic        ex_stall,
  output logic [3:0]  rf_rs,
  output logic [3:0]  rf_rt,
  input  logic [15:0] rf_out_rs,
  input  logic [15:0] rf_out_rt,
  input  logic        wb_we,
  input  logic [3:0]  wb_rd,
  input  logic [15:0] wb_data,
  output logic        ex_valid,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_rd,
  output logic [3:0]  ex_rs,
  output logic [3:0]  ex_rt,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [7:0]  ex_imm,
  output logic        hlt
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  imm;
  } id_ex_t;

  typedef enum logic [2:0] {
    A_NORM,
    A_FLUSH,
    A_HOLD,
    A_HALT,
    A_BUBBLE
  } act_t;

  id_ex_t ex_q;
  logic   hlt_q;
  act_t   act;

  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic        uses_rs;
  logic        uses_rt;
  logic        load_hz;
  logic        raw_hz;
  logic        hz;
  logic [15:0] opa;
  logic [15:0] opb;

  assign op = if_instr[15:12];
  assign rd = if_instr[11:8];
  assign rs = if_instr[7:4];
  assign rt = if_instr[3:0];

  assign rf_rs = rs;
  assign rf_rt = rt;

  assign uses_rs = (op != HLT_OP);
  assign uses_rt = ~op[3];

  assign load_hz = if_valid && ex_q.valid &&
                   ex_q.opcode == LW_OP &&
                   ex_q.rd != 4'd0 &&
                   ((uses_rs && ex_q.rd == rs) ||
                    (uses_rt && ex_q.rd == rt));

`ifdef ID_FWD_EN
  always_comb begin
    opa = rf_out_rs;
    opb = rf_out_rt;
    if (rs == 4'd0)
      opa = 16'h0000;
    else if (wb_we && wb_rd == rs)
      opa = wb_data;
    if (rt == 4'd0)
      opb = 16'h0000;
    else if (wb_we && wb_rd == rt)
      opb = wb_data;
  end

  assign raw_hz = 1'b0;
`else
  assign opa = (rs == 4'd0) ? 16'h0000 : rf_out_rs;
  assign opb = (rt == 4'd0) ? 16'h0000 : rf_out_rt;

  // Without forwarding a same-cycle writeback must land before reading.
  assign raw_hz = if_valid && wb_we && wb_rd != 4'd0 &&
                  ((uses_rs && wb_rd == rs) ||
                   (uses_rt && wb_rd == rt));
`endif

  assign hz = load_hz || raw_hz;

  always_comb begin
    act = A_NORM;
    priority case (1'b1)
      flush:    act = A_FLUSH;
      ex_stall: act = A_HOLD;
      hlt_q:    act = A_HALT;
      hz:       act = A_BUBBLE;
      default:  act = A_NORM;
    endcase
  end

  assign if_stall = (act == A_HOLD) ||
                    (act == A_HALT) ||
                    (act == A_BUBBLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      hlt_q <= 1'b0;
    end else begin
      unique case (act)
        A_FLUSH: ex_q.valid <= 1'b0;
        A_HOLD: begin
          // Held entry must still see results retiring behind it.
          if (ex_q.valid && wb_we && wb_rd != 4'd0) begin
            if (wb_rd == ex_q.rs)
              ex_q.a <= wb_data;
            if (wb_rd == ex_q.rt)
              ex_q.b <= wb_data;
          end
        end
        A_HALT:   ex_q.valid <= 1'b0;
        A_BUBBLE: ex_q.valid <= 1'b0;
        default: begin
          if (if_valid) begin
            ex_q.valid  <= 1'b1;
            ex_q.opcode <= op;
            ex_q.rd     <= rd;
            ex_q.rs     <= rs;
            ex_q.rt     <= rt;
            ex_q.a      <= opa;
            ex_q.b      <= opb;
            ex_q.imm    <= if_instr[7:0];
            if (op == HLT_OP)
              hlt_q <= 1'b1;
          end else begin
            ex_q.valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ex_valid  = ex_q.valid;
  assign ex_opcode = ex_q.opcode;
  assign ex_rd     = ex_q.rd;
  assign ex_rs     = ex_q.rs;
  assign ex_rt     = ex_q.rt;
  assign ex_a      = ex_q.a;
  assign ex_b      = ex_q.b;
  assign ex_imm    = ex_q.imm;
  assign hlt       = hlt_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage; expectations follow the ID_FWD_EN setting.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_stall;
  logic        flush;
  logic        ex_stall;
  logic [3:0]  rf_rs;
  logic [3:0]  rf_rt;
  logic [15:0] rf_out_rs;
  logic [15:0] rf_out_rt;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [3:0]  ex_rd;
  logic [3:0]  ex_rs;
  logic [3:0]  ex_rt;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic [7:0]  ex_imm;
  logic        hlt;

  int total = 0;
  int bad = 0;

  id_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr),
    .if_stall(if_stall), .flush(flush),
    .ex_stall(ex_stall),
    .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_out_rs(rf_out_rs), .rf_out_rt(rf_out_rt),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .hlt(hlt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0;
    flush = 1'b0; ex_stall = 1'b0;
    rf_out_rs = 16'h0; rf_out_rt = 16'h0;
    wb_we = 1'b0; wb_rd = 4'h0; wb_data = 16'h0;
    #12;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ex_valid); end
    total++; if (hlt !== 1'b0) begin bad++; $display("FAIL rst_hlt got=%b want=0", hlt); end
    total++; if (ex_a !== 16'h0) begin bad++; $display("FAIL rst_a got=%h want=0000", ex_a); end
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", if_stall); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    if_valid = 1'b1; if_instr = 16'h1123;
    rf_out_rs = 16'h00AA; rf_out_rt = 16'h0055;
    #1;
    total++; if ({rf_rs, rf_rt} !== 8'h23) begin bad++; $display("FAIL rf_addr got=%h want=23", {rf_rs, rf_rt}); end
    tick;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", ex_valid); end
    total++; if (ex_a !== 16'h00AA) begin bad++; $display("FAIL basic_a got=%h want=00aa", ex_a); end
    total++; if (ex_b !== 16'h0055) begin bad++; $display("FAIL basic_b got=%h want=0055", ex_b); end
    total++; if (ex_rd !== 4'h1) begin bad++; $display("FAIL basic_rd got=%h want=1", ex_rd); end
    total++; if (ex_imm !== 8'h23) begin bad++; $display("FAIL basic_imm got=%h want=23", ex_imm); end
  endtask

  task automatic test_r0;
    if_instr = 16'h1120; rf_out_rt = 16'hFFFF;
    tick;
    total++; if (ex_b !== 16'h0000) begin bad++; $display("FAIL r0_b got=%h want=0000", ex_b); end
    total++; if (ex_a !== 16'h00AA) begin bad++; $display("FAIL r0_a got=%h want=00aa", ex_a); end
  endtask

  task automatic test_wb;
    if_instr = 16'h1124; rf_out_rs = 16'h0BAD; rf_out_rt = 16'h0055;
    wb_we = 1'b1; wb_rd = 4'h2; wb_data = 16'h1234;
    #1;
`ifdef ID_FWD_EN
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL fwd_stall got=%b want=0", if_stall); end
    tick;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid got=%b want=1", ex_valid); end
    total++; if (ex_a !== 16'h1234) begin bad++; $display("FAIL fwd_a got=%h want=1234", ex_a); end
    total++; if (ex_b !== 16'h0055) begin bad++; $display("FAIL fwd_b got=%h want=0055", ex_b); end
    wb_we = 1'b0;
`else
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b want=1", if_stall); end
    tick;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL raw_bubble got=%b want=0", ex_valid); end
    wb_we = 1'b0;
    #1;
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL raw_release got=%b want=0", if_stall); end
    tick;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL raw_valid got=%b want=1", ex_valid); end
    total++; if (ex_a !== 16'h0BAD) begin bad++; $display("FAIL raw_a got=%h want=0bad", ex_a); end
`endif
  endtask

  task automatic test_load_use;
    if_instr = 16'h8400;
    tick;
    total++; if ({ex_valid, ex_opcode, ex_rd} !== 9'h184) begin bad++; $display("FAIL lw_load got=%h want=184", {ex_valid, ex_opcode, ex_rd}); end
    if_instr = 16'h1543; rf_out_rs = 16'h0444; rf_out_rt = 16'h0333;
    #1;
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", if_stall); end
    tick;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b want=0", ex_valid); end
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b want=0", if_stall); end
    tick;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_valid got=%b want=1", ex_valid); end
    total++; if (ex_rd !== 4'h5) begin bad++; $display("FAIL lu_rd got=%h want=5", ex_rd); end
    total++; if (ex_a !== 16'h0444) begin bad++; $display("FAIL lu_a got=%h want=0444", ex_a); end
  endtask

  task automatic test_ex_stall;
    ex_stall = 1'b1; if_instr = 16'h1267;
    rf_out_rs = 16'h0666; rf_out_rt = 16'h0777;
    #1;
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL hold_stall0 got=%b want=1", if_stall); end
    tick;
    total++; if (ex_rd !== 4'h5 || ex_a !== 16'h0444) begin bad++; $display("FAIL hold1 got=%h/%h want=5/0444", ex_rd, ex_a); end
    wb_we = 1'b1; wb_rd = 4'h4; wb_data = 16'hBEEF;
    tick;
    total++; if (ex_a !== 16'hBEEF) begin bad++; $display("FAIL hold_refresh got=%h want=beef", ex_a); end
    total++; if (ex_b !== 16'h0333) begin bad++; $display("FAIL hold_b got=%h want=0333", ex_b); end
    wb_we = 1'b0;
    tick;
    total++; if ({ex_valid, ex_rd, if_stall} !== 6'b1_0101_1) begin bad++; $display("FAIL hold3 got=%b want=101011", {ex_valid, ex_rd, if_stall}); end
    ex_stall = 1'b0;
    tick;
    total++; if (ex_rd !== 4'h2 || ex_a !== 16'h0666) begin bad++; $display("FAIL hold_exit got=%h/%h want=2/0666", ex_rd, ex_a); end
  endtask

  task automatic test_back_to_back;
    if_instr = 16'h2456; rf_out_rs = 16'h0005; rf_out_rt = 16'h0006;
    tick;
    if_instr = 16'h3789; rf_out_rs = 16'h0008; rf_out_rt = 16'h0009;
    total++; if ({ex_opcode, ex_rd, ex_b} !== 24'h240006) begin bad++; $display("FAIL b2b_0 got=%h want=240006", {ex_opcode, ex_rd, ex_b}); end
    tick;
    total++; if ({ex_opcode, ex_rd, ex_a} !== 24'h370008) begin bad++; $display("FAIL b2b_1 got=%h want=370008", {ex_opcode, ex_rd, ex_a}); end
  endtask

  task automatic test_flush_hlt;
    if_instr = 16'hF000; flush = 1'b1;
    #1;
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", if_stall); end
    tick;
    total++; if ({ex_valid, hlt} !== 2'b00) begin bad++; $display("FAIL flush_hlt got=%b want=00", {ex_valid, hlt}); end
    flush = 1'b0;
    tick;
    total++; if ({ex_valid, hlt, ex_opcode} !== 6'b11_1111) begin bad++; $display("FAIL hlt_set got=%b want=111111", {ex_valid, hlt, ex_opcode}); end
    if_instr = 16'h1123;
    #1;
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL hlt_stall got=%b want=1", if_stall); end
    tick;
    total++; if ({ex_valid, hlt} !== 2'b01) begin bad++; $display("FAIL hlt_bubble got=%b want=01", {ex_valid, hlt}); end
    tick;
    total++; if ({hlt, if_stall} !== 2'b11) begin bad++; $display("FAIL hlt_sticky got=%b want=11", {hlt, if_stall}); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({ex_valid, hlt} !== 2'b00) begin bad++; $display("FAIL async_rst got=%b want=00", {ex_valid, hlt}); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_r0;
    test_wb;
    test_load_use;
    test_ex_stall;
    test_back_to_back;
    test_flush_hlt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
